// File: rtl/time_field_selector_if.sv
// Display-selector bus: mode/cursor controls and field vectors in, registered display fields out.
// Inputs are sampled on the consumer clock; nothing here is stateful.
interface time_field_selector_if #(
    parameter int FIELDS = 2,
    parameter int WIDTH  = 6
);
    localparam int CW = (FIELDS > 1) ? $clog2(FIELDS) : 1;

    logic                      setTime;
    logic                      nextField;
    logic [FIELDS*WIDTH-1:0]   live_in;
    logic [FIELDS*WIDTH-1:0]   edit_in;
    logic [FIELDS*WIDTH-1:0]   disp_out;
    logic [FIELDS-1:0]         blank_mask;
    logic [CW-1:0]             cursor;
    logic                      commit;

    modport master (
        output setTime, nextField, live_in, edit_in,
        input  disp_out, blank_mask, cursor, commit
    );

    modport slave (
        input  setTime, nextField, live_in, edit_in,
        output disp_out, blank_mask, cursor, commit
    );
endinterface

// File: rtl/time_field_selector.sv
// Registers live or edit fields onto the display bus; in set mode tracks the edit cursor and blinks it.
// One-cycle latency on every output, no backpressure: a new selection is accepted every cycle.
module time_field_selector #(
    parameter int FIELDS    = 2,
    parameter int WIDTH     = 6,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    time_field_selector_if.slave  bus
);
    localparam int CW = (FIELDS > 1) ? $clog2(FIELDS) : 1;
    localparam int NW = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] CUR_LAST = CW'(FIELDS - 1);
    localparam logic [NW-1:0] CNT_LAST = NW'(BLINK_DIV - 1);

    typedef enum logic {
        RUN = 1'b0,
        SET = 1'b1
    } mode_t;

    mode_t                    r_mode;
    mode_t                    w_mode_nxt;
    logic [CW-1:0]            r_cursor;
    logic [CW-1:0]            w_cursor_nxt;
    logic [NW-1:0]            r_cnt;
    logic [NW-1:0]            w_cnt_nxt;
    logic                     r_phase;
    logic                     w_phase_nxt;
    logic                     r_commit;
    logic                     w_commit_nxt;
    logic [FIELDS*WIDTH-1:0]  r_disp;
    logic [FIELDS-1:0]        w_blank;

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            r_mode <= RUN;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    always_comb begin : next_state
        w_mode_nxt = bus.setTime ? SET : RUN;
    end

    // Cursor/blink bookkeeping; every restart of the blink leaves the field visible.
    always_comb begin : ctrl_nxt
        w_cursor_nxt = r_cursor;
        w_cnt_nxt    = '0;
        w_phase_nxt  = 1'b1;
        w_commit_nxt = 1'b0;
        if (r_mode == RUN) begin
            if (bus.setTime) begin
                w_cursor_nxt = '0;
            end
        end else if (!bus.setTime) begin
            w_commit_nxt = 1'b1;
        end else if (bus.nextField) begin
            w_cursor_nxt = (r_cursor == CUR_LAST) ? '0 : r_cursor + 1'b1;
        end else if (r_cnt == CNT_LAST) begin
            w_phase_nxt = ~r_phase;
        end else begin
            w_cnt_nxt   = r_cnt + 1'b1;
            w_phase_nxt = r_phase;
        end
    end

    always_ff @(posedge clk) begin : ctrl_reg
        if (rst) begin
            r_cursor <= '0;
            r_cnt    <= '0;
            r_phase  <= 1'b1;
            r_commit <= 1'b0;
            r_disp   <= '0;
        end else begin
            r_cursor <= w_cursor_nxt;
            r_cnt    <= w_cnt_nxt;
            r_phase  <= w_phase_nxt;
            r_commit <= w_commit_nxt;
            r_disp   <= bus.setTime ? bus.edit_in : bus.live_in;
        end
    end

    // Decoded from registers only so the mask is glitch-free toward the display driver.
    always_comb begin : output_dec
        w_blank = '0;
        if (r_mode == SET && !r_phase) begin
            w_blank = FIELDS'(1) << r_cursor;
        end
    end

    assign bus.disp_out   = r_disp;
    assign bus.blank_mask = w_blank;
    assign bus.cursor     = r_cursor;
    assign bus.commit     = r_commit;
endmodule

// File: tb/tb_time_field_selector.sv
module tb_time_field_selector;
    localparam int F  = 3;
    localparam int W  = 6;
    localparam int BD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    time_field_selector_if #(.FIELDS(F), .WIDTH(W)) bus();

    time_field_selector #(.FIELDS(F), .WIDTH(W), .BLINK_DIV(BD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          r;
        bit          s;
        bit          nf;
        logic [17:0] live;
        logic [17:0] edit;
        logic [17:0] disp;
        logic [2:0]  blank;
        logic [1:0]  cur;
        bit          commit;
    } vec_t;

    vec_t tbl[$];

    // Reference state: blink derived from elapsed cycles since the last restart.
    bit          m_set = 0;
    int          m_cur = 0;
    int          m_since = 0;
    logic [17:0] m_disp = '0;
    bit          m_commit = 0;

    function automatic logic [17:0] pack3(input int a, input int b, input int c);
        return {6'(c), 6'(b), 6'(a)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input bit r, input bit s, input bit nf, input logic [17:0] lv,
                       input logic [17:0] ed, input logic [17:0] dp, input logic [2:0] bl,
                       input logic [1:0] cu, input bit cm);
        vec_t v;
        v.r = r; v.s = s; v.nf = nf; v.live = lv; v.edit = ed;
        v.disp = dp; v.blank = bl; v.cur = cu; v.commit = cm;
        tbl.push_back(v);
    endtask

    task automatic step(input bit r, input bit s, input bit nf,
                        input logic [17:0] lv, input logic [17:0] ed);
        int exp_blank;
        rst = r;
        bus.setTime = s;
        bus.nextField = nf;
        bus.live_in = lv;
        bus.edit_in = ed;
        @(posedge clk);
        #1;
        m_commit = 0;
        if (r) begin
            m_set = 0; m_cur = 0; m_since = 0; m_disp = '0;
        end else begin
            m_disp = s ? ed : lv;
            if (!m_set && s) begin
                m_set = 1; m_cur = 0; m_since = 0;
            end else if (m_set && !s) begin
                m_set = 0; m_commit = 1; m_since = 0;
            end else if (m_set) begin
                if (nf) begin
                    m_cur = (m_cur + 1) % F;
                    m_since = 0;
                end else begin
                    m_since++;
                end
            end else begin
                m_since = 0;
            end
        end
        exp_blank = (m_set && ((m_since / BD) % 2 == 1)) ? (1 << m_cur) : 0;
        chk("model_disp", 32'(bus.disp_out), 32'(m_disp));
        chk("model_blank", 32'(bus.blank_mask), 32'(exp_blank));
        chk("model_cursor", 32'(bus.cursor), 32'(m_cur));
        chk("model_commit", 32'(bus.commit), 32'(m_commit));
    endtask

    initial begin
        logic [17:0] L, E, L2, lv, ed;
        bit s, nf, r;
        int commits;

        bus.setTime = 1'b0;
        bus.nextField = 1'b0;
        bus.live_in = '0;
        bus.edit_in = '0;

        L  = pack3(5, 12, 34);
        E  = pack3(1, 2, 3);
        L2 = pack3(7, 8, 9);

        add(1, 0, 0, L, E, '0, 3'b000, 2'd0, 0);
        add(0, 0, 0, L, E, L,  3'b000, 2'd0, 0);
        add(0, 1, 0, L, E, E,  3'b000, 2'd0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 0, L, E, E, 3'b000, 2'd0, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 0, L, E, E, 3'b001, 2'd0, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 0, L, E, E, 3'b000, 2'd0, 0);
        add(0, 1, 0, L, E, E, 3'b001, 2'd0, 0);
        add(0, 1, 1, L, E, E, 3'b000, 2'd1, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 0, L, E, E, 3'b000, 2'd1, 0);
        add(0, 1, 0, L, E, E, 3'b010, 2'd1, 0);
        add(0, 0, 0, L, E, L, 3'b000, 2'd1, 1);
        add(0, 0, 0, L2, E, L2, 3'b000, 2'd1, 0);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].s, tbl[i].nf, tbl[i].live, tbl[i].edit);
            chk($sformatf("tbl%0d_disp", i), 32'(bus.disp_out), 32'(tbl[i].disp));
            chk($sformatf("tbl%0d_blank", i), 32'(bus.blank_mask), 32'(tbl[i].blank));
            chk($sformatf("tbl%0d_cursor", i), 32'(bus.cursor), 32'(tbl[i].cur));
            chk($sformatf("tbl%0d_commit", i), 32'(bus.commit), 32'(tbl[i].commit));
        end

        // RUN hold: nextField ignored, no commit, no blanking.
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1'($urandom_range(1)), L, E);
            chk("run_hold_commit", 32'(bus.commit), 32'd0);
            chk("run_hold_blank", 32'(bus.blank_mask), 32'd0);
            chk("run_hold_cursor", 32'(bus.cursor), 32'd1);
        end

        // Cursor stepping with wrap, 10 cycles per pulse.
        step(0, 1, 0, L, E);
        chk("enter_set_cursor", 32'(bus.cursor), 32'd0);
        for (int p = 0; p < 3; p++) begin
            step(0, 1, 1, L, E);
            chk("nf_cursor", 32'(bus.cursor), 32'((p + 1) % 3));
            chk("nf_blank0", 32'(bus.blank_mask), 32'd0);
            for (int i = 1; i < 10; i++) begin
                step(0, 1, 0, L, E);
                chk("nf_blank", 32'(bus.blank_mask),
                    (i >= 4 && i < 8) ? 32'(1 << ((p + 1) % 3)) : 32'd0);
            end
        end

        // nextField coinciding with the last count of a half-period.
        step(0, 1, 1, L, E);
        for (int i = 0; i < 3; i++) step(0, 1, 0, L, E);
        step(0, 1, 1, L, E);
        chk("nf_at_wrap_cursor", 32'(bus.cursor), 32'd2);
        chk("nf_at_wrap_blank", 32'(bus.blank_mask), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 0, L, E);
            chk("nf_at_wrap_after", 32'(bus.blank_mask), (i == 4) ? 32'b100 : 32'd0);
        end

        // Reset while blanked, then a single-cycle set pulse.
        step(1, 1, 0, L, E);
        chk("rst_disp", 32'(bus.disp_out), 32'd0);
        chk("rst_blank", 32'(bus.blank_mask), 32'd0);
        chk("rst_cursor", 32'(bus.cursor), 32'd0);
        chk("rst_commit", 32'(bus.commit), 32'd0);
        step(0, 1, 0, L, E);
        chk("pulse_disp", 32'(bus.disp_out), 32'(E));
        commits = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, L2, E);
            if (bus.commit) commits++;
        end
        chk("pulse_commit_count", 32'(commits), 32'd1);

        // Randomized traffic against the reference.
        s = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(15) == 0) s = ~s;
            nf = ($urandom_range(7) == 0);
            r  = ($urandom_range(199) == 0);
            lv = 18'($urandom);
            ed = 18'($urandom);
            step(r, s, nf, lv, ed);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
